// File: rtl/ddr_port0_writer.sv
// Write-side MCB port controller: streams raster-ordered pixel results into DDR
// frame memory as write bursts of up to MAX_BURST words from BASE_ADDR upward.
module ddr_port0_writer #(
    parameter logic [29:0] BASE_ADDR = 30'd0,
    parameter int          MAX_BURST = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic        frame_start,
    input  logic [20:0] total_pixels,
    input  logic [31:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        wr_full,
    input  logic [6:0]  wr_count,
    input  logic        cmd_full,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    output logic        cmd_en,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [20:0] MAX_BURST_W = 21'(MAX_BURST);

    typedef enum logic [1:0] {
        CALIB = 2'd0,
        IDLE  = 2'd1,
        FILL  = 2'd2,
        CMD   = 2'd3
    } state_t;

    function automatic logic [6:0] clip_len(input logic [20:0] remaining);
        if (remaining > MAX_BURST_W) begin
            clip_len = MAX_BURST_W[6:0];
        end else begin
            clip_len = remaining[6:0];
        end
    endfunction

    state_t      state_r, state_s;
    logic        calib_meta_r, calib_sync_r;
    logic [20:0] total_r, word_ptr_r, next_ptr_s;
    logic [6:0]  burst_cnt_r, burst_len_r;
    logic [5:0]  cmd_bl_r;
    logic [29:0] cmd_addr_r;
    logic        cmd_en_r, busy_r, frame_done_r, done_pend_r;
    logic        pix_ready_s, accept_s, start_s, issue_s;
    logic        unused_s;

    assign unused_s      = ^wr_count;
    assign accept_s      = pix_valid & pix_ready_s;
    assign pix_ready     = pix_ready_s;
    assign wr_en         = accept_s;
    assign wr_data       = pix_data;
    assign wr_mask       = 4'b0000;
    assign cmd_instr     = 3'b000;
    assign cmd_bl        = cmd_bl_r;
    assign cmd_byte_addr = cmd_addr_r;
    assign cmd_en        = cmd_en_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;

    // Two-flop synchroniser for the asynchronous calibration flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calib_meta_r <= 1'b0;
            calib_sync_r <= 1'b0;
        end else begin
            calib_meta_r <= mem_calib_done;
            calib_sync_r <= calib_meta_r;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_s     = state_r;
        pix_ready_s = 1'b0;
        start_s     = 1'b0;
        issue_s     = 1'b0;
        next_ptr_s  = word_ptr_r + {14'd0, burst_len_r};
        case (state_r)
            CALIB: begin
                if (calib_sync_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = CALIB;
                end
            end
            IDLE: begin
                // A start coinciding with (or just ahead of) frame_done is dropped
                if (frame_start && !done_pend_r && !frame_done_r) begin
                    start_s = 1'b1;
                    if (total_pixels == 21'd0) begin
                        state_s = IDLE;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                pix_ready_s = !wr_full && (burst_cnt_r < burst_len_r);
                if (pix_valid && pix_ready_s && ((burst_cnt_r + 7'd1) == burst_len_r)) begin
                    state_s = CMD;
                end else begin
                    state_s = FILL;
                end
            end
            CMD: begin
                if (!cmd_full) begin
                    issue_s = 1'b1;
                    if (next_ptr_s == total_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = CMD;
                end
            end
            default: begin
                state_s = CALIB;
            end
        endcase
    end

    // State, burst bookkeeping and registered command/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= CALIB;
            total_r      <= 21'd0;
            word_ptr_r   <= 21'd0;
            burst_cnt_r  <= 7'd0;
            burst_len_r  <= 7'd0;
            cmd_bl_r     <= 6'd0;
            cmd_addr_r   <= 30'd0;
            cmd_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            done_pend_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cmd_en_r     <= issue_s;
            done_pend_r  <= issue_s && (next_ptr_s == total_r);
            frame_done_r <= done_pend_r || (start_s && (total_pixels == 21'd0));
            if (start_s) begin
                total_r     <= total_pixels;
                word_ptr_r  <= 21'd0;
                burst_cnt_r <= 7'd0;
                burst_len_r <= clip_len(total_pixels);
                busy_r      <= (total_pixels != 21'd0);
            end else if (issue_s) begin
                cmd_bl_r    <= 6'(burst_len_r - 7'd1);
                cmd_addr_r  <= BASE_ADDR + {7'd0, word_ptr_r, 2'b00};
                word_ptr_r  <= next_ptr_s;
                burst_cnt_r <= 7'd0;
                burst_len_r <= clip_len(total_r - next_ptr_s);
            end else if (accept_s) begin
                burst_cnt_r <= burst_cnt_r + 7'd1;
            end else if (done_pend_r) begin
                busy_r <= 1'b0;
            end else begin
                burst_cnt_r <= burst_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_ddr_port0_writer.sv
// Self-checking bench for ddr_port0_writer: queue scoreboard for write data and
// write commands, with frame-level count checks around each scenario.
module tb_ddr_port0_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_calib_done = 1'b0;
    logic        frame_start = 1'b0;
    logic [20:0] total_pixels = 21'd0;
    logic [31:0] pix_data = 32'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        wr_full = 1'b0;
    logic [6:0]  wr_count = 7'd0;
    logic        cmd_full = 1'b0;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_en;
    logic        busy;
    logic        frame_done;

    ddr_port0_writer #(.BASE_ADDR(30'd0), .MAX_BURST(64)) dut (
        .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
        .frame_start(frame_start), .total_pixels(total_pixels),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .wr_full(wr_full), .wr_count(wr_count), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
        .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_en(cmd_en), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt = 0, cmd_cnt = 0, done_cnt = 0, last_cmd_cyc = 0, burst_words = 0;
    logic [31:0] exp_wr_q[$];
    logic [35:0] exp_cmd_q[$];

    int frame_id = 0, src_total = 0, src_tag = 0;
    bit src_on = 1'b0, src_rand = 1'b0, force_valid = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input int tag, input int i);
        return (32'(tag) << 24) ^ (32'(i) * 32'h0001_0001 + 32'h0000_0101);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel source: holds each word until it is taken, optional random valid gaps
    initial begin : source
        int  idx;
        int  seen;
        bit  taken;
        idx = 0;
        seen = 0;
        forever begin
            @(negedge clk);
            taken = pix_valid & pix_ready;
            @(posedge clk);
            #2;
            if (seen != frame_id) begin
                idx = 0;
                seen = frame_id;
            end else if (taken) begin
                idx++;
            end
            if (src_on) begin
                if (idx < src_total) begin
                    pix_valid = src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                    pix_data  = word_of(src_tag, idx);
                end else begin
                    pix_valid = 1'b0;
                end
            end else begin
                pix_valid = force_valid;
            end
        end
    end

    // Monitor: scoreboard pops for commands and write data, frame_done accounting
    always @(negedge clk) begin
        if (reset) begin
            exp_wr_q.delete();
            exp_cmd_q.delete();
            burst_words = 0;
        end else begin
            if (cmd_en) begin
                chk_eq("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'd1);
                if (exp_cmd_q.size() != 0) begin
                    chk_eq("cmd_bl_addr", {28'd0, cmd_bl, cmd_byte_addr}, {28'd0, exp_cmd_q.pop_front()});
                end
                chk_eq("cmd_instr", cmd_instr, 64'd0);
                chk_eq("burst_data_first", burst_words, 64'(cmd_bl) + 64'd1);
                burst_words = 0;
                cmd_cnt++;
                last_cmd_cyc = cyc;
            end
            if (wr_en) begin
                chk_eq("wr_while_full", wr_full, 64'd0);
                chk_eq("wr_mask", wr_mask, 64'd0);
                chk_eq("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    chk_eq("wr_data", wr_data, exp_wr_q.pop_front());
                end
                wr_cnt++;
                burst_words++;
            end
            if (frame_done) begin
                done_cnt++;
                chk_eq("done_cmds_drained", exp_cmd_q.size(), 64'd0);
                chk_eq("done_after_cmd", 64'(cyc > last_cmd_cyc), 64'd1);
                chk_eq("done_busy_clear", busy, 64'd0);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input int total, input int tag, input bit rnd);
        int ptr;
        int len;
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        total_pixels = 21'(total);
        src_total = total;
        src_tag = tag;
        src_rand = rnd;
        src_on = 1'b1;
        frame_id++;
        for (int i = 0; i < total; i++) exp_wr_q.push_back(word_of(tag, i));
        ptr = 0;
        while (ptr < total) begin
            len = (total - ptr > 64) ? 64 : total - ptr;
            exp_cmd_q.push_back({6'(len - 1), 30'(ptr * 4)});
            ptr += len;
        end
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        total_pixels = 21'h1_5A5A;
    endtask

    task automatic wait_done(input int d0, input int budget, input bit tog);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            #1;
            if (tog) wr_full = ((k / 3) % 2) == 1;
            k++;
        end
        wr_full = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_checks(input string tag, input int w0, input int c0, input int d0,
                                input int words, input int cmds);
        chk_eq({tag, "_done_once"}, done_cnt - d0, 64'd1);
        chk_eq({tag, "_words"}, wr_cnt - w0, words);
        chk_eq({tag, "_cmds"}, cmd_cnt - c0, cmds);
        chk_eq({tag, "_wq_left"}, exp_wr_q.size(), 64'd0);
        chk_eq({tag, "_cq_left"}, exp_cmd_q.size(), 64'd0);
    endtask

    task automatic run_frame(input string tag, input int total, input int tag_id,
                             input bit rnd, input bit tog, input int cmds);
        int w0, c0, d0;
        w0 = wr_cnt;
        c0 = cmd_cnt;
        d0 = done_cnt;
        start_frame(total, tag_id, rnd);
        wait_done(d0, 4000, tog);
        frame_checks(tag, w0, c0, d0, total, cmds);
    endtask

    initial begin : main
        int w0, c0, d0, rdy_seen, cmd_seen, k;

        // Reset state
        @(negedge clk);
        chk_eq("rst_pix_ready", pix_ready, 64'd0);
        chk_eq("rst_wr_en", wr_en, 64'd0);
        chk_eq("rst_cmd_en", cmd_en, 64'd0);
        chk_eq("rst_busy_done", {busy, frame_done}, 64'd0);
        chk_eq("rst_cmd_fields", {cmd_instr, cmd_bl, cmd_byte_addr}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Calibration gate
        force_valid = 1'b1;
        rdy_seen = 0;
        cmd_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            frame_start = (i == 50);
            total_pixels = 21'd10;
            @(negedge clk);
            if (pix_ready) rdy_seen++;
            if (cmd_en) cmd_seen++;
        end
        frame_start = 1'b0;
        chk_eq("calib_gate_ready", rdy_seen, 64'd0);
        chk_eq("calib_gate_cmd", cmd_seen, 64'd0);
        mem_calib_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pix_ready) rdy_seen++;
        end
        chk_eq("calib_post_ready", rdy_seen, 64'd0);
        chk_eq("calib_post_busy", busy, 64'd0);
        force_valid = 1'b0;

        // Partial last burst: (63,0) (63,256) (1,512)
        run_frame("partial130", 130, 1, 1'b0, 1'b0, 3);

        // Write-FIFO backpressure with random valid
        run_frame("bp64", 64, 2, 1'b1, 1'b1, 1);

        // Command FIFO stall
        w0 = wr_cnt; c0 = cmd_cnt; d0 = done_cnt;
        @(posedge clk);
        #1;
        cmd_full = 1'b1;
        start_frame(64, 3, 1'b0);
        k = 0;
        while ((wr_cnt - w0) < 64 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk_eq("stall_filled", wr_cnt - w0, 64'd64);
        rdy_seen = 0;
        cmd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_ready) rdy_seen++;
            if (cmd_en) cmd_seen++;
        end
        chk_eq("stall_no_cmd", cmd_seen, 64'd0);
        chk_eq("stall_no_ready", rdy_seen, 64'd0);
        @(posedge clk);
        #1;
        cmd_full = 1'b0;
        @(negedge clk);
        chk_eq("stall_cmd_not_early", cmd_en, 64'd0);
        @(negedge clk);
        chk_eq("stall_cmd_follows", cmd_en, 64'd1);
        wait_done(d0, 200, 1'b0);
        frame_checks("stall64", w0, c0, d0, 64, 1);

        // Zero-pixel frame
        c0 = cmd_cnt; d0 = done_cnt;
        start_frame(0, 4, 1'b0);
        @(negedge clk);
        chk_eq("zero_done_pulse", frame_done, 64'd1);
        @(negedge clk);
        chk_eq("zero_done_single", frame_done, 64'd0);
        chk_eq("zero_busy", busy, 64'd0);
        repeat (5) @(negedge clk);
        chk_eq("zero_no_cmd", cmd_cnt - c0, 64'd0);
        chk_eq("zero_done_cnt", done_cnt - d0, 64'd1);

        // frame_start mid-frame is ignored: bl 63,63,63,63,43, last addr 1024
        w0 = wr_cnt; c0 = cmd_cnt; d0 = done_cnt;
        start_frame(300, 5, 1'b0);
        k = 0;
        while ((wr_cnt - w0) < 100 && k < 500) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        total_pixels = 21'd5;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(negedge clk);
        chk_eq("midstart_busy", busy, 64'd1);
        wait_done(d0, 4000, 1'b0);
        frame_checks("mid300", w0, c0, d0, 300, 5);

        // Reset mid-burst
        start_frame(64, 6, 1'b0);
        k = 0;
        w0 = wr_cnt;
        while ((wr_cnt - w0) < 10 && k < 500) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_calib_done = 1'b0;
        src_on = 1'b0;
        #1;
        chk_eq("rstmid_ready_wren", {pix_ready, wr_en}, 64'd0);
        chk_eq("rstmid_cmd_en", cmd_en, 64'd0);
        chk_eq("rstmid_busy_done", {busy, frame_done}, 64'd0);
        chk_eq("rstmid_cmd_fields", {cmd_instr, cmd_bl, cmd_byte_addr}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mem_calib_done = 1'b1;
        repeat (6) @(posedge clk);
        run_frame("post_rst64", 64, 7, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
